// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer width, legal synchronizer depths and the
// Gray-to-binary decode used by both pointer-crossing blocks.
package fifo_pkg;

  localparam int default_address_size = 3;
  localparam int ptr_w                 = default_address_size + 1;
  localparam int max_ptr_w             = 32;
  localparam int min_sync_stages       = 2;
  localparam int max_sync_stages       = 4;

  function automatic int ptr_width(input int address_size);
    return address_size + 1;
  endfunction

  function automatic bit sync_stages_legal(input int stages);
    return (stages >= min_sync_stages) && (stages <= max_sync_stages);
  endfunction

  // Callers zero-extend into the 32-bit argument; zeros above the real MSB
  // leave the decode of the meaningful bits unchanged.
  function automatic logic [max_ptr_w-1:0] gray2bin(input logic [max_ptr_w-1:0] gray);
    logic [max_ptr_w-1:0] bin;
    bin[max_ptr_w-1] = gray[max_ptr_w-1];
    for (int i = max_ptr_w - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_stage_chain.sv
// Generic N-bit, M-stage flop chain with asynchronous active-low clear,
// used for both directions of FIFO pointer crossing.
module sync_stage_chain #(
  parameter int width  = 4,
  parameter int stages = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  // Stage 0 is the metastability-catching flop; its input path is declared
  // false in the timing constraints.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
  logic [width-1:0] stage_reg [stages];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < stages; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < stages; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[stages-1];

endmodule

// File: rtl/sync_read_to_write.sv
// Carries the Gray-coded read pointer into the write clock domain and
// provides a binary copy for write-side occupancy arithmetic.
module sync_read_to_write
  import fifo_pkg::*;
#(
  parameter int address_size = 3,
  parameter int sync_stages  = 2
) (
  input  logic                  write_clk,
  input  logic                  write_reset_n,
  input  logic [address_size:0] read_pointer,
  output logic [address_size:0] write_to_read_pointer,
  output logic [address_size:0] write_to_read_pointer_bin
);

  localparam int pw = ptr_width(address_size);

  generate
    if (!sync_stages_legal(sync_stages)) begin : g_bad_cfg
      $error("sync_read_to_write: sync_stages=%0d outside legal range 2..4", sync_stages);
    end
  endgenerate

  sync_stage_chain #(
    .width  (pw),
    .stages (sync_stages)
  ) u_chain (
    .clk     (write_clk),
    .clear_n (write_reset_n),
    .d       (read_pointer),
    .q       (write_to_read_pointer)
  );

  assign write_to_read_pointer_bin = pw'(gray2bin(max_ptr_w'(write_to_read_pointer)));

endmodule

// File: tb/tb_sync_read_to_write.sv
// Scoreboard bench: stimulus queues expected outputs with the cycle they are
// due; per-DUT monitors pop and compare on the falling edge.
module tb_sync_read_to_write;

  typedef struct {
    int         due;
    logic [4:0] gray;
    logic [4:0] bin;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rp = 4'b0101;
  logic [3:0] out_g, out_b;
  logic [4:0] rp_p = 5'b0;
  logic [4:0] out_pg, out_pb;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_def[$];
  exp_t q_swp[$];

  sync_read_to_write dut (
    .write_clk                 (clk),
    .write_reset_n             (rst_n),
    .read_pointer              (rp),
    .write_to_read_pointer     (out_g),
    .write_to_read_pointer_bin (out_b)
  );

  sync_read_to_write #(.address_size(4), .sync_stages(3)) dut_p (
    .write_clk                 (clk),
    .write_reset_n             (rst_n),
    .read_pointer              (rp_p),
    .write_to_read_pointer     (out_pg),
    .write_to_read_pointer_bin (out_pb)
  );

  // Rising edges at 10, 20, 30 ... ns
  always begin
    #5 clk = 1'b0;
    #5 clk = 1'b1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t it;
    while (q_def.size() > 0 && q_def[0].due <= cyc) begin
      it = q_def.pop_front();
      checks++;
      if (it.due != cyc || out_g !== it.gray[3:0] || out_b !== it.bin[3:0]) begin
        errors++;
        $display("FAIL %s cyc=%0d: got ptr=%b bin=%b, want ptr=%b bin=%b (due %0d)",
                 it.name, cyc, out_g, out_b, it.gray[3:0], it.bin[3:0], it.due);
      end else begin
        $display("ok   %s cyc=%0d ptr=%b bin=%0d", it.name, cyc, out_g, out_b);
      end
    end
  end

  always @(negedge clk) begin
    exp_t it;
    while (q_swp.size() > 0 && q_swp[0].due <= cyc) begin
      it = q_swp.pop_front();
      checks++;
      if (it.due != cyc || out_pg !== it.gray || out_pb !== it.bin) begin
        errors++;
        $display("FAIL %s cyc=%0d: got ptr=%b bin=%0d, want ptr=%b bin=%0d (due %0d)",
                 it.name, cyc, out_pg, out_pb, it.gray, it.bin, it.due);
      end else begin
        $display("ok   %s cyc=%0d ptr=%b bin=%0d", it.name, cyc, out_pg, out_pb);
      end
    end
  end

  task automatic check_now(input string nm, input logic [3:0] want_g, input logic [3:0] want_b);
    checks++;
    if (out_g !== want_g || out_b !== want_b) begin
      errors++;
      $display("FAIL %s t=%0t: got ptr=%b bin=%b, want ptr=%b bin=%b",
               nm, $time, out_g, out_b, want_g, want_b);
    end else begin
      $display("ok   %s t=%0t ptr=%b bin=%b", nm, $time, out_g, out_b);
    end
  endtask

  // Apply a new pointer just after an edge; it is sampled on the next edge
  // and appears after the second (default depth 2).
  task automatic drive(input logic [3:0] g, input logic [3:0] b, input string nm);
    @(posedge clk);
    #1;
    rp = g;
    q_def.push_back('{due: cyc + 2, gray: {1'b0, g}, bin: {1'b0, b}, name: nm});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q_def.size() > 0 || q_swp.size() > 0); i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q_def.size() != 0 || q_swp.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations still pending, want 0",
               q_def.size(), q_swp.size());
    end
  endtask

  initial begin
    int r;

    // Reset behaviour: async clear mid-cycle, refill two edges after release
    #3  rst_n = 1'b1;
    #19 check_now("reset_pre_value", 4'b0101, 4'b0110);
    #3  rst_n = 1'b0;
    #1  check_now("reset_async_clear", 4'b0000, 4'b0000);
    #9  rst_n = 1'b1;
    #10 check_now("reset_one_edge", 4'b0000, 4'b0000);
    #10 check_now("reset_refill", 4'b0101, 4'b0110);

    // Step sequence, one change per cycle, then held to show no duplication
    drive(4'b0000, 4'd0, "step0");
    drive(4'b0001, 4'd1, "step1");
    drive(4'b0011, 4'd2, "step2");
    drive(4'b0010, 4'd3, "step3");
    drive(4'b0110, 4'd4, "step4");
    drive(4'b0110, 4'd4, "step4_hold");

    // Wrap-around from Gray 15 back to 0
    drive(4'b1000, 4'd15, "wrap15");
    drive(4'b0000, 4'd0, "wrap0");
    drive(4'b0000, 4'd0, "wrap0_hold");
    drain(10);

    // Reset while 0001 is in flight; it must never reach the output
    @(posedge clk); #1 rp = 4'b0001;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_now("midflight_clear", 4'b0000, 4'b0000);
    rp = 4'b0011;
    @(posedge clk); #1;
    check_now("midflight_held", 4'b0000, 4'b0000);
    #2 rst_n = 1'b1;
    r = cyc;
    q_def.push_back('{due: r + 1, gray: 5'b00000, bin: 5'd0, name: "midflight_empty"});
    q_def.push_back('{due: r + 2, gray: 5'b00011, bin: 5'd2, name: "midflight_refill"});
    q_def.push_back('{due: r + 3, gray: 5'b00011, bin: 5'd2, name: "midflight_steady"});
    drain(10);

    // Depth-3, 5-bit instance: every Gray code, latency exactly 3 edges
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      rp_p = 5'(i ^ (i >> 1));
      q_swp.push_back('{due: cyc + 3, gray: 5'(i ^ (i >> 1)), bin: 5'(i),
                        name: $sformatf("sweep%0d", i)});
    end
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 ns");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
